// File: rtl/ll_resp_queue_pkg.sv
// Shared core definitions for the load/store response queue: default widths
// and branch-mask helpers reused by execution units.
package ll_resp_queue_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_PAY_W = 65;
   localparam int DEF_BR_W  = 20;

   // Helpers work on the widest mask any core configuration uses; callers
   // zero-extend their BR_W-wide masks and truncate results back down.
   localparam int MAX_BR_W  = 64;

   typedef logic [MAX_BR_W-1:0] br_mask_t;

   function automatic logic is_killed(br_mask_t mask, br_mask_t mispredict);
      return |(mask & mispredict);
   endfunction

   function automatic br_mask_t update_mask(br_mask_t mask, br_mask_t resolve);
      return mask & ~resolve;
   endfunction

endpackage

// File: rtl/ll_resp_queue_if.sv
// Enqueue/dequeue handshake, branch-update and status bundle of the response queue.
interface ll_resp_queue_if
   import ll_resp_queue_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PAY_W = DEF_PAY_W,
   parameter int BR_W  = DEF_BR_W
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             enq_valid;
   logic             enq_ready;
   logic [BR_W-1:0]  enq_br_mask;
   logic [PAY_W-1:0] enq_payload;

   logic             deq_valid;
   logic             deq_ready;
   logic [BR_W-1:0]  deq_br_mask;
   logic [PAY_W-1:0] deq_payload;

   logic [BR_W-1:0]  brupdate_resolve_mask;
   logic [BR_W-1:0]  brupdate_mispredict_mask;
   logic             flush;

   logic             empty;
   logic [CNT_W-1:0] count;

   modport master (
      output enq_valid, enq_br_mask, enq_payload, deq_ready,
             brupdate_resolve_mask, brupdate_mispredict_mask, flush,
      input  enq_ready, deq_valid, deq_br_mask, deq_payload, empty, count
   );

   modport slave (
      input  enq_valid, enq_br_mask, enq_payload, deq_ready,
             brupdate_resolve_mask, brupdate_mispredict_mask, flush,
      output enq_ready, deq_valid, deq_br_mask, deq_payload, empty, count
   );

endinterface

// File: rtl/ll_resp_queue.sv
// Circular response queue with per-slot branch masks: mispredicted entries die
// in place and are reclaimed one per cycle when they reach the head.
module ll_resp_queue
   import ll_resp_queue_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PAY_W = DEF_PAY_W,
   parameter int BR_W  = DEF_BR_W
) (
   input logic           clock,
   input logic           reset,
   ll_resp_queue_if.slave q
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt, occ;
   logic [IDX_W-1:0] head_idx, tail_idx;
   logic [DEPTH-1:0] live, live_nxt, kill_vec;
   logic [CNT_W-1:0] count_q, count_nxt;

   logic [BR_W-1:0]  br_mask [DEPTH];
   logic [PAY_W-1:0] payload [DEPTH];

   logic occupied, head_dead, deq_valid, deq_fire;
   logic enq_ready, enq_take;

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];
   assign occ      = tail - head;
   assign occupied = (occ != '0);

   always_comb begin
      kill_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         kill_vec[i] = live[i] & is_killed(br_mask_t'(br_mask[i]),
                                           br_mask_t'(q.brupdate_mispredict_mask));
   end

   // Occupancy is taken from registered pointers, so a dequeue in the same
   // cycle never opens a slot for the enqueue.
   assign enq_ready = (occ != FULL);
   assign enq_take  = q.enq_valid & enq_ready & ~q.flush &
                      ~is_killed(br_mask_t'(q.enq_br_mask),
                                 br_mask_t'(q.brupdate_mispredict_mask));

   assign deq_valid = occupied & live[head_idx] & ~kill_vec[head_idx] & ~q.flush;
   assign deq_fire  = deq_valid & q.deq_ready;
   assign head_dead = occupied & ~live[head_idx];

   assign q.enq_ready   = enq_ready;
   assign q.deq_valid   = deq_valid;
   assign q.deq_payload = payload[head_idx];
   assign q.deq_br_mask = BR_W'(update_mask(br_mask_t'(br_mask[head_idx]),
                                            br_mask_t'(q.brupdate_resolve_mask)));
   assign q.count       = count_q;
   assign q.empty       = (count_q == '0);

   always_comb begin
      live_nxt = live & ~kill_vec;
      head_nxt = head + PTR_W'(deq_fire | head_dead);
      tail_nxt = tail + PTR_W'(enq_take);
      if (deq_fire)
         live_nxt[head_idx] = 1'b0;
      if (enq_take)
         live_nxt[tail_idx] = 1'b1;
      if (q.flush) begin
         live_nxt = '0;
         head_nxt = tail;
      end
      count_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         count_nxt = count_nxt + CNT_W'(live_nxt[i]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         live    <= '0;
         count_q <= '0;
      end else begin
         head    <= head_nxt;
         tail    <= tail_nxt;
         live    <= live_nxt;
         count_q <= count_nxt;
      end
   end

   // Data storage is qualified by the live bits and needs no reset.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         br_mask[i] <= BR_W'(update_mask(br_mask_t'(br_mask[i]),
                                         br_mask_t'(q.brupdate_resolve_mask)));
         if (enq_take && (tail_idx == IDX_W'(i))) begin
            br_mask[i] <= BR_W'(update_mask(br_mask_t'(q.enq_br_mask),
                                            br_mask_t'(q.brupdate_resolve_mask)));
            payload[i] <= q.enq_payload;
         end
      end
   end

endmodule

// File: tb/tb_ll_resp_queue.sv
// Directed and random stimulus for ll_resp_queue, checked against a queue-based
// reference model of live/dead entries.
module tb_ll_resp_queue;

   localparam int DEPTH = 4;
   localparam int PAY_W = 65;
   localparam int BR_W  = 20;

   typedef struct {
      bit               live;
      logic [BR_W-1:0]  m;
      logic [PAY_W-1:0] p;
   } ent_t;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;
   ent_t mq[$];

   ll_resp_queue_if #(.DEPTH(DEPTH), .PAY_W(PAY_W), .BR_W(BR_W)) bus ();

   ll_resp_queue #(.DEPTH(DEPTH), .PAY_W(PAY_W), .BR_W(BR_W)) dut (
      .clock (clock),
      .reset (reset),
      .q     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_live();
      int n = 0;
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].live) n++;
      return n;
   endfunction

   function automatic bit model_deq_valid();
      if (mq.size() == 0) return 1'b0;
      return mq[0].live && ((mq[0].m & bus.brupdate_mispredict_mask) == '0) && !bus.flush;
   endfunction

   // One clock: compare outputs mid-cycle, then advance the model at the edge.
   task automatic cycle();
      bit dv, dead, take;
      int occ;
      @(negedge clock);
      occ = mq.size();
      dv  = model_deq_valid();
      check("enq_ready", bus.enq_ready, occ < DEPTH);
      check("deq_valid", bus.deq_valid, dv);
      check("count", bus.count, model_live());
      check("empty", bus.empty, model_live() == 0);
      if (dv) begin
         check("deq_payload", bus.deq_payload, mq[0].p);
         check("deq_br_mask", bus.deq_br_mask, mq[0].m & ~bus.brupdate_resolve_mask);
      end
      @(posedge clock);
      if (reset) begin
         mq.delete();
      end else begin
         dead = (occ > 0) && !mq[0].live;
         take = bus.enq_valid && (occ < DEPTH) && !bus.flush &&
                ((bus.enq_br_mask & bus.brupdate_mispredict_mask) == '0);
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].live && ((mq[i].m & bus.brupdate_mispredict_mask) != '0))
               mq[i].live = 1'b0;
            mq[i].m = mq[i].m & ~bus.brupdate_resolve_mask;
         end
         if (bus.flush) begin
            mq.delete();
         end else begin
            if ((dv && bus.deq_ready) || dead)
               void'(mq.pop_front());
            if (take)
               mq.push_back('{1'b1, bus.enq_br_mask & ~bus.brupdate_resolve_mask, bus.enq_payload});
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.enq_valid = 1'b0;
      bus.enq_br_mask = '0;
      bus.enq_payload = '0;
      bus.deq_ready = 1'b0;
      bus.brupdate_resolve_mask = '0;
      bus.brupdate_mispredict_mask = '0;
      bus.flush = 1'b0;
   endtask

   task automatic enq(input logic [BR_W-1:0] m, input logic [PAY_W-1:0] p);
      bus.enq_valid = 1'b1;
      bus.enq_br_mask = m;
      bus.enq_payload = p;
      cycle();
      bus.enq_valid = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_deq_valid", bus.deq_valid, 1'b0);
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1'b1);
      check("rst_enq_ready", bus.enq_ready, 1'b1);
      reset = 1'b0;
      mq.delete();
      cycle();

      // fill and drain
      for (int i = 0; i < 4; i++) enq('0, PAY_W'(8'h11 + i));
      check("fill_enq_ready", bus.enq_ready, 1'b0);
      check("fill_count", bus.count, 4);
      bus.enq_valid = 1'b1;
      bus.enq_payload = PAY_W'(8'h55);
      cycle();
      bus.enq_valid = 1'b0;
      bus.deq_ready = 1'b1;
      repeat (4) cycle();
      check("drain_empty", bus.empty, 1'b1);
      check("drain_count", bus.count, 0);
      bus.deq_ready = 1'b0;

      // mispredict kill
      enq(20'h1, PAY_W'(8'hA1));
      enq(20'h2, PAY_W'(8'hA2));
      enq(20'h1, PAY_W'(8'hA3));
      bus.brupdate_mispredict_mask = 20'h1;
      cycle();
      bus.brupdate_mispredict_mask = '0;
      check("kill_count", bus.count, 1);
      check("kill_deq_valid", bus.deq_valid, 1'b0);
      bus.deq_ready = 1'b1;
      repeat (4) cycle();
      check("kill_empty", bus.empty, 1'b1);
      bus.deq_ready = 1'b0;

      // resolve
      enq(20'h6, PAY_W'(8'hB6));
      bus.brupdate_resolve_mask = 20'h2;
      #1;
      check("resolve_same_cycle", bus.deq_br_mask, 20'h4);
      cycle();
      bus.brupdate_resolve_mask = '0;
      #1;
      check("resolve_after", bus.deq_br_mask, 20'h4);
      bus.deq_ready = 1'b1;
      repeat (2) cycle();
      bus.deq_ready = 1'b0;

      // flush with a concurrent enqueue
      for (int i = 0; i < 3; i++) enq('0, PAY_W'(8'hC0 + i));
      bus.flush = 1'b1;
      bus.enq_valid = 1'b1;
      bus.enq_payload = PAY_W'(8'hCF);
      cycle();
      idle_inputs();
      check("flush_count", bus.count, 0);
      check("flush_empty", bus.empty, 1'b1);
      check("flush_deq_valid", bus.deq_valid, 1'b0);
      bus.deq_ready = 1'b1;
      repeat (2) cycle();

      // back-to-back wrap
      for (int i = 0; i < 10; i++) enq('0, PAY_W'(16'h100 + i));
      repeat (2) cycle();

      // reset mid-stream
      bus.deq_ready = 1'b0;
      enq('0, PAY_W'(8'hD1));
      enq('0, PAY_W'(8'hD2));
      bus.deq_ready = 1'b1;
      reset = 1'b1;
      #1;
      mq.delete();
      check("midrst_deq_valid", bus.deq_valid, 1'b0);
      check("midrst_count", bus.count, 0);
      check("midrst_enq_ready", bus.enq_ready, 1'b1);
      cycle();
      reset = 1'b0;
      idle_inputs();
      cycle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.enq_valid = ($urandom_range(0, 3) != 0);
         bus.enq_br_mask = BR_W'($urandom_range(0, 15));
         bus.enq_payload = PAY_W'({$urandom(), $urandom()});
         bus.deq_ready = ($urandom_range(0, 2) != 0);
         bus.brupdate_resolve_mask = ($urandom_range(0, 3) == 0) ? BR_W'($urandom_range(0, 15)) : '0;
         bus.brupdate_mispredict_mask = ($urandom_range(0, 7) == 0) ?
                                        (BR_W'(1) << $urandom_range(0, 3)) : '0;
         bus.flush = ($urandom_range(0, 49) == 0);
         cycle();
      end
      idle_inputs();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ll_resp_queue.md
LL_RESP_QUEUE -- requirements
Module: ll_resp_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-002 Parameter PAY_W, default 65, payload width (data + uop fields + fflags).
REQ-003 Parameter BR_W, default 20, branch-mask width.
REQ-004 Port list: clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enq_valid  in  1; enq_ready  out  1; enq_br_mask  in  BR_W; enq_payload  in  PAY_W.
REQ-007 deq_valid  out  1; deq_ready  in  1; deq_br_mask  out  BR_W; deq_payload  out  PAY_W.
REQ-008 brupdate_resolve_mask  in  BR_W; brupdate_mispredict_mask  in  BR_W  (one-hot or zero).
REQ-009 flush  in  1  kill everything.
REQ-010 empty  out  1  no live entries.
REQ-011 count  out  $clog2(DEPTH+1)  live-entry count.

Function
REQ-012 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH; per slot: live bit, br_mask, payload.
REQ-013 Occupied slots SHALL be those from head up to, but not including, tail; a killed slot stays occupied (not live) until head passes it.
REQ-014 enq_ready SHALL be 1 iff occupied slots < DEPTH; a simultaneous dequeue SHALL NOT free a slot in the same cycle.
REQ-015 On enq_valid & enq_ready: write at tail, advance tail, store br_mask = enq_br_mask & ~resolve_mask.
REQ-016 If enq_br_mask & mispredict_mask is nonzero, or flush=1, an offered enqueue SHALL be dropped with tail unchanged; enq_ready is unaffected.
REQ-017 Every cycle, each live slot with (br_mask & mispredict_mask) nonzero SHALL clear its live bit; every slot SHALL clear br_mask bits set in resolve_mask.
REQ-018 deq_valid SHALL be 1 iff the head slot is occupied, live, (br_mask & mispredict_mask)==0, and flush=0.
REQ-019 deq_br_mask SHALL equal head br_mask & ~resolve_mask; deq_payload SHALL equal the head payload; both are don't-care when deq_valid=0.
REQ-020 On deq_valid & deq_ready, head SHALL advance by one.
REQ-021 If the head slot is occupied and not live, head SHALL advance by one that cycle with deq_valid=0 (one dead slot reclaimed per cycle).
REQ-022 Latency: an entry accepted in cycle t SHALL appear at deq no earlier than t+1; no enq-to-deq bypass.
REQ-023 On flush: all live bits clear and head=tail on the next edge; deq_valid=0 in the flush cycle.
REQ-024 count and empty SHALL be registered and reflect live entries after the current edge's updates; empty = (count==0).
REQ-025 Simultaneous enqueue, dequeue, resolve and mispredict SHALL all take effect in the same cycle, in the order kill/resolve, then enqueue/dequeue.

Reset
REQ-026 While reset=1: head=tail=0, all live bits 0, count=0, empty=1, deq_valid=0, enq_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, with no dequeue handshake completed in that cycle.
REQ-028 Payload and br_mask storage need not be reset.

Structure
REQ-029 Mask helpers (is_killed(mask, mispredict), update_mask(mask, resolve)) and default widths SHALL live in the shared core package, for reuse by execution units.
REQ-030 No sub-module is needed; the block is a single module whose storage is a flop array.

Verification (DEPTH=4, BR_W=20)
REQ-031 Fill and drain: enqueue payloads 0x11..0x14 with masks 0, deq_ready=0 -> enq_ready=0 and count=4; then deq_ready=1 -> 0x11..0x14 are dequeued in order, and empty=1 after the fourth.
REQ-032 Mispredict kill: entries with masks 0x1, 0x2, 0x1; mispredict_mask=0x1 -> count drops 3->1 next cycle; only the 0x2 entry is dequeued, and dead slots are reclaimed one per cycle.
REQ-033 Resolve: entry with mask 0x6, resolve_mask=0x2 -> deq_br_mask=0x4 in the same cycle and thereafter.
REQ-034 Flush with an enqueue in the same cycle: 3 live entries, flush=1, enq_valid=1 -> next cycle count=0, empty=1, deq_valid=0, and the offered entry is absent.
REQ-035 Wrap and boundaries: 10 back-to-back enq/deq with deq_ready=1 -> pointers wrap, order is preserved, and 1-cycle latency holds; asserting reset mid-stream -> deq_valid=0 and count=0 immediately.
